// File: rtl/frame_bank_scheduler_if.sv
// Frame bank scheduler bus: frame pulses from the capture and display sides,
// plus the bank/base selections and statistics the scheduler publishes.
interface frame_bank_scheduler_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              wrFrameStart;
  logic              wrFrameDone;
  logic              rdFrameStart;
  logic              clrStats;
  logic [1:0]        wrBank;
  logic [1:0]        rdBank;
  logic [ADDR_W-1:0] wrBase;
  logic [ADDR_W-1:0] rdBase;
  logic              wrActive;
  logic              displayValid;
  logic [7:0]        dropCnt;
  logic [7:0]        repeatCnt;
  logic [7:0]        abortCnt;

  modport master (
    output wrFrameStart, wrFrameDone, rdFrameStart, clrStats,
    input  wrBank, rdBank, wrBase, rdBase, wrActive, displayValid,
           dropCnt, repeatCnt, abortCnt
  );

  modport slave (
    input  wrFrameStart, wrFrameDone, rdFrameStart, clrStats,
    output wrBank, rdBank, wrBase, rdBase, wrActive, displayValid,
           dropCnt, repeatCnt, abortCnt
  );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer controller: rotates read/write/spare roles over three RAM
// banks on frame boundaries so the display never shows a torn frame.
module frame_bank_scheduler #(
  parameter int unsigned BANK_WORDS     = 4800,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input logic                   clk,
  input logic                   rst,
  frame_bank_scheduler_if.slave bus
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // All three banks must fit in the physical address space.
  if (64'(3) * 64'(BANK_WORDS) > (64'(1) << ADDR_W)) begin : g_bank_fit
    $error("frame_bank_scheduler: 3*BANK_WORDS exceeds 2**ADDR_W");
  end

  typedef enum logic {
    IDLE,
    ACTIVE
  } wr_state_t;

  wr_state_t         state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [1:0]        r_q, r_d;
  logic [1:0]        w_q, w_d;
  logic [1:0]        s_q, s_d;
  logic              sv_q, sv_d;
  logic              dv_q, dv_d;
  logic [ADDR_W-1:0] rbase_q, wbase_q;
  logic [7:0]        drop_q, rep_q, abort_q;
  logic              commit;
  logic              drop_inc, rep_inc, abort_inc;

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] b);
    case (b)
      2'd1:    return ADDR_W'(BANK_WORDS);
      2'd2:    return ADDR_W'(2 * BANK_WORDS);
      default: return '0;
    endcase
  endfunction

  function automatic logic [7:0] bump(input logic [7:0] c, input logic inc, input logic clr);
    if (clr)                  return '0;
    else if (inc && c != '1)  return c + 8'd1;
    else                      return c;
  endfunction

  // Writer FSM, timeout and bank-role rotation next-state logic.
  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    r_d       = r_q;
    w_d       = w_q;
    s_d       = s_q;
    sv_d      = sv_q;
    dv_d      = dv_q;
    commit    = 1'b0;
    drop_inc  = 1'b0;
    rep_inc   = 1'b0;
    abort_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.wrFrameStart) begin
          state_d = ACTIVE;
          to_d    = '0;
        end
      end
      ACTIVE: begin
        if (bus.wrFrameDone) begin
          commit = 1'b1;
          to_d   = '0;
          if (!bus.wrFrameStart) state_d = IDLE;
        end else if (bus.wrFrameStart) begin
          // Restart takes precedence over a coincident timeout: one abort.
          abort_inc = 1'b1;
          to_d      = '0;
        end else if (to_q == TO_LAST) begin
          abort_inc = 1'b1;
          to_d      = '0;
          state_d   = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit && bus.rdFrameStart) begin
      // Fresh frame goes straight to display; any pending spare is dropped.
      r_d = w_q;
      if (sv_q) begin
        w_d      = s_q;
        s_d      = r_q;
        drop_inc = 1'b1;
      end else begin
        w_d = r_q;
      end
      sv_d = 1'b0;
      dv_d = 1'b1;
    end else if (commit) begin
      w_d      = s_q;
      s_d      = w_q;
      drop_inc = sv_q;
      sv_d     = 1'b1;
    end else if (bus.rdFrameStart) begin
      if (sv_q) begin
        r_d  = s_q;
        s_d  = r_q;
        sv_d = 1'b0;
        dv_d = 1'b1;
      end else if (dv_q) begin
        rep_inc = 1'b1;
      end
    end
  end

  // State, role, base and statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      to_q    <= '0;
      r_q     <= 2'd0;
      w_q     <= 2'd1;
      s_q     <= 2'd2;
      sv_q    <= 1'b0;
      dv_q    <= 1'b0;
      rbase_q <= '0;
      wbase_q <= ADDR_W'(BANK_WORDS);
      drop_q  <= '0;
      rep_q   <= '0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      r_q     <= r_d;
      w_q     <= w_d;
      s_q     <= s_d;
      sv_q    <= sv_d;
      dv_q    <= dv_d;
      rbase_q <= base_of(r_d);
      wbase_q <= base_of(w_d);
      drop_q  <= bump(drop_q,  drop_inc,  bus.clrStats);
      rep_q   <= bump(rep_q,   rep_inc,   bus.clrStats);
      abort_q <= bump(abort_q, abort_inc, bus.clrStats);
    end
  end

  assign bus.rdBank       = r_q;
  assign bus.wrBank       = w_q;
  assign bus.rdBase       = rbase_q;
  assign bus.wrBase       = wbase_q;
  assign bus.wrActive     = (state_q == ACTIVE);
  assign bus.displayValid = dv_q;
  assign bus.dropCnt      = drop_q;
  assign bus.repeatCnt    = rep_q;
  assign bus.abortCnt     = abort_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Bench for frame_bank_scheduler: frame-level reference model compared every
// cycle, plus directed sequences with literal expectations.
module tb_frame_bank_scheduler;
  localparam int unsigned BW = 4800;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  frame_bank_scheduler_if #(.ADDR_W(AW)) bus ();

  frame_bank_scheduler #(
    .BANK_WORDS(BW),
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Frame-level model: displayed bank, bank being filled, newest unread bank.
  int m_rd = 0, m_wr = 1, m_pend = 0;
  bit m_has_pend = 0, m_dv = 0, m_act = 0;
  int m_age = 0, m_drop = 0, m_rep = 0, m_abort = 0;
  int nrd, nwr, npend, nage;
  bit nhp, ndv, nact, commit, ev_drop, ev_rep, ev_abort;

  function automatic int sat(input int c, input bit ev, input bit clr);
    if (clr) return 0;
    if (ev && c < 255) return c + 1;
    return c;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rd <= 0; m_wr <= 1; m_pend <= 0; m_has_pend <= 0; m_dv <= 0;
      m_act <= 0; m_age <= 0; m_drop <= 0; m_rep <= 0; m_abort <= 0;
    end else begin
      commit = m_act && bus.wrFrameDone;
      ev_abort = 0; ev_drop = 0; ev_rep = 0;
      nact = m_act; nage = m_age + 1;
      if (!m_act) begin
        if (bus.wrFrameStart) begin nact = 1; nage = 0; end
      end else if (bus.wrFrameDone) begin
        nact = bus.wrFrameStart; nage = 0;
      end else if (bus.wrFrameStart) begin
        ev_abort = 1; nage = 0;
      end else if (m_age == TO - 1) begin
        ev_abort = 1; nact = 0; nage = 0;
      end
      nrd = m_rd; nwr = m_wr; npend = m_pend; nhp = m_has_pend; ndv = m_dv;
      if (commit && bus.rdFrameStart) begin
        nrd = m_wr;
        nwr = m_has_pend ? m_pend : m_rd;
        ev_drop = m_has_pend;
        nhp = 0; ndv = 1;
      end else if (commit) begin
        nwr = 3 - m_rd - m_wr;
        ev_drop = m_has_pend;
        npend = m_wr; nhp = 1;
      end else if (bus.rdFrameStart) begin
        if (m_has_pend) begin nrd = m_pend; nhp = 0; ndv = 1; end
        else if (m_dv) ev_rep = 1;
      end
      m_rd <= nrd; m_wr <= nwr; m_pend <= npend; m_has_pend <= nhp; m_dv <= ndv;
      m_act <= nact; m_age <= nage;
      m_drop  <= sat(m_drop,  ev_drop,  bus.clrStats);
      m_rep   <= sat(m_rep,   ev_rep,   bus.clrStats);
      m_abort <= sat(m_abort, ev_abort, bus.clrStats);
    end
  end

  // Per-cycle comparison of every output against the model.
  logic [63:0] exp_v, act_v;
  always @(negedge clk) begin
    cycle++;
    exp_v = {2'b00, 2'(m_rd), 2'(m_wr), AW'(m_rd * BW), AW'(m_wr * BW), m_act, m_dv,
             8'(m_drop), 8'(m_rep), 8'(m_abort)};
    act_v = {2'b00, bus.rdBank, bus.wrBank, bus.rdBase, bus.wrBase, bus.wrActive,
             bus.displayValid, bus.dropCnt, bus.repeatCnt, bus.abortCnt};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL outputs cycle %0d: got %h want %h", cycle, act_v, exp_v);
    end
    checks++;
    if (bus.rdBank === bus.wrBank) begin
      errors++;
      $display("FAIL bank_distinct cycle %0d: rdBank %0d wrBank %0d", cycle, bus.rdBank, bus.wrBank);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic ws, input logic wd, input logic rs, input logic cs);
    bus.wrFrameStart = ws;
    bus.wrFrameDone  = wd;
    bus.rdFrameStart = rs;
    bus.clrStats     = cs;
    @(posedge clk);
    #1;
    bus.wrFrameStart = 1'b0;
    bus.wrFrameDone  = 1'b0;
    bus.rdFrameStart = 1'b0;
    bus.clrStats     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic frame();
    cyc(1, 0, 0, 0);
    idle(10);
    cyc(0, 1, 0, 0);
  endtask

  initial begin
    bus.wrFrameStart = 1'b0;
    bus.wrFrameDone  = 1'b0;
    bus.rdFrameStart = 1'b0;
    bus.clrStats     = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    check("reset_rdBank", bus.rdBank, 0);
    check("reset_wrBank", bus.wrBank, 1);
    check("reset_rdBase", bus.rdBase, 0);
    check("reset_wrBase", bus.wrBase, 4800);
    check("reset_dv", bus.displayValid, 0);
    check("reset_wrActive", bus.wrActive, 0);

    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    check("noframe_rdBank", bus.rdBank, 0);
    check("noframe_wrBank", bus.wrBank, 1);
    check("noframe_dv", bus.displayValid, 0);
    check("noframe_repeat", bus.repeatCnt, 0);

    cyc(1, 0, 0, 0);
    check("start_wrActive", bus.wrActive, 1);
    idle(40);
    cyc(0, 1, 0, 0);
    check("commit_wrBank", bus.wrBank, 2);
    check("commit_wrBase", bus.wrBase, 9600);
    check("commit_rdBank", bus.rdBank, 0);
    check("commit_wrActive", bus.wrActive, 0);
    cyc(0, 0, 1, 0);
    check("read_rdBank", bus.rdBank, 1);
    check("read_rdBase", bus.rdBase, 4800);
    check("read_wrBank", bus.wrBank, 2);
    check("read_dv", bus.displayValid, 1);

    frame();
    check("f1_wrBank", bus.wrBank, 0);
    frame();
    check("f2_wrBank", bus.wrBank, 2);
    check("f2_drop", bus.dropCnt, 1);
    cyc(0, 0, 1, 0);
    check("f2_rdBank", bus.rdBank, 0);
    check("f2_wrBank_after_read", bus.wrBank, 2);

    frame();
    check("pre_coinc_wrBank", bus.wrBank, 1);
    cyc(1, 0, 0, 0);
    idle(10);
    cyc(0, 1, 1, 0);
    check("coinc_rdBank", bus.rdBank, 1);
    check("coinc_wrBank", bus.wrBank, 2);
    check("coinc_drop", bus.dropCnt, 2);
    cyc(0, 0, 1, 0);
    check("repeat_cnt", bus.repeatCnt, 1);
    check("repeat_rdBank", bus.rdBank, 1);

    cyc(1, 0, 0, 0);
    idle(49);
    check("to_still_active", bus.wrActive, 1);
    idle(1);
    check("to_inactive", bus.wrActive, 0);
    check("to_abort", bus.abortCnt, 1);
    check("to_rdBank", bus.rdBank, 1);
    check("to_wrBank", bus.wrBank, 2);
    cyc(1, 0, 0, 0);
    idle(5);
    cyc(1, 0, 0, 0);
    check("restart_abort", bus.abortCnt, 2);
    check("restart_active", bus.wrActive, 1);
    cyc(0, 1, 0, 0);
    check("restart_commit_wrBank", bus.wrBank, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    check("clr_beats_inc_repeat", bus.repeatCnt, 0);
    check("clr_drop", bus.dropCnt, 0);
    check("clr_abort", bus.abortCnt, 0);

    for (int i = 0; i < 300; i++) begin
      cyc(1, 0, 0, 0);
      idle(2);
      cyc(0, 1, 0, 0);
    end
    check("drop_saturate", bus.dropCnt, 255);
    for (int i = 0; i < 300; i++) begin
      cyc(0, 0, 1, 0);
      idle(1);
    end
    check("repeat_saturate", bus.repeatCnt, 255);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, 0, 0, 0);
    check("abort_saturate", bus.abortCnt, 255);
    cyc(0, 0, 0, 1);
    check("clr_all", bus.dropCnt + bus.repeatCnt + bus.abortCnt, 0);

    for (int i = 0; i < 60000; i++) begin
      if (i == 30000) begin
        cyc(1, 0, 0, 0);
        idle(5);
        rst = 1'b0;
        #2;
        check("midreset_wrActive", bus.wrActive, 0);
        check("midreset_rdBank", bus.rdBank, 0);
        check("midreset_wrBank", bus.wrBank, 1);
        check("midreset_counts", bus.dropCnt + bus.repeatCnt + bus.abortCnt, 0);
        @(posedge clk);
        #1 rst = 1'b1;
      end
      cyc($urandom_range(39, 0) == 0, $urandom_range(29, 0) == 0,
          $urandom_range(59, 0) == 0, $urandom_range(4999, 0) == 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
